// File: rtl/motor_pwm_ramp.sv
// motor_pwm_ramp: NCH-channel motor PWM with per-channel direction and slew-limited duty ramping.
// Applied duty/direction only change on period boundaries, so the H-bridge never sees a glitch.
module motor_pwm_ramp #(
  parameter int NCH      = 2,
  parameter int DW       = 10,
  parameter int CLK_HZ   = 100_000_000,
  parameter int PWM_HZ   = 25_000,
  parameter int STEP     = 8,
  parameter int RAMP_DIV = 1,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           brake,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [CHW-1:0] cmd_ch,
  input  logic [DW-1:0]  cmd_duty,
  input  logic           cmd_dir,
  output logic [NCH-1:0] pwm,
  output logic [NCH-1:0] dir,
  output logic [NCH-1:0] at_target,
  output logic           period_tick
);

  localparam int PERIOD = CLK_HZ / PWM_HZ;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DVW    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [CW-1:0]    CNT_LAST = CW'(PERIOD - 1);
  localparam logic [DVW-1:0]   DIV_LAST = DVW'(RAMP_DIV - 1);
  localparam logic [DW:0]      STEP_X   = (DW+1)'(STEP);
  localparam logic [DW+31:0]   PERIOD_X = (DW+32)'(PERIOD);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DVW-1:0] div_q, div_d;
  logic           ready_q, ready_d;
  logic [NCH-1:0] pwm_q, pwm_d;
  logic [NCH-1:0] tgt_dir_q, tgt_dir_d;
  logic [NCH-1:0] cur_dir_q, cur_dir_d;
  logic [DW-1:0]  tgt_duty_q [NCH];
  logic [DW-1:0]  tgt_duty_d [NCH];
  logic [DW-1:0]  cur_duty_q [NCH];
  logic [DW-1:0]  cur_duty_d [NCH];
  logic [CW-1:0]  cmp_q [NCH];
  logic [CW-1:0]  cmp_d [NCH];

  logic [DW:0]    cur_x [NCH];
  logic [DW:0]    tgt_x [NCH];
  logic [DW:0]    up_x  [NCH];
  logic [DW:0]    dn_x  [NCH];
  logic [DW:0]    nxt_x [NCH];
  logic [DW+31:0] prod  [NCH];

  logic boundary, ramp_tick, accept;

  always_comb begin
    boundary  = en && (cnt_q == CNT_LAST);
    ramp_tick = boundary && (div_q == DIV_LAST);
    accept    = cmd_valid && cmd_ready;
    cnt_d     = (en && !boundary) ? cnt_q + 1'b1 : '0;
    div_d     = div_q;
    if (ramp_tick)     div_d = '0;
    else if (boundary) div_d = div_q + 1'b1;
    ready_d   = 1'b1;
    tgt_dir_d = tgt_dir_q;
    cur_dir_d = cur_dir_q;
    pwm_d     = '0;
    for (int i = 0; i < NCH; i++) begin
      tgt_duty_d[i] = tgt_duty_q[i];
      cur_duty_d[i] = cur_duty_q[i];
      cmp_d[i]      = cmp_q[i];
      cur_x[i]      = {1'b0, cur_duty_q[i]};
      tgt_x[i]      = {1'b0, tgt_duty_q[i]};
      up_x[i]       = cur_x[i] + STEP_X;
      dn_x[i]       = (cur_x[i] > STEP_X) ? cur_x[i] - STEP_X : '0;
      nxt_x[i]      = cur_x[i];
      // A reversal must drain to zero before the direction is allowed to flip.
      if (cur_dir_q[i] != tgt_dir_q[i]) begin
        if (cur_x[i] != '0)           nxt_x[i] = dn_x[i];
        else if (ramp_tick && !brake) cur_dir_d[i] = tgt_dir_q[i];
      end else if (cur_x[i] < tgt_x[i]) begin
        nxt_x[i] = (up_x[i] > tgt_x[i]) ? tgt_x[i] : up_x[i];
      end else if (cur_x[i] > tgt_x[i]) begin
        nxt_x[i] = (dn_x[i] < tgt_x[i]) ? tgt_x[i] : dn_x[i];
      end
      prod[i] = (DW+32)'(nxt_x[i]) * PERIOD_X;
      if (ramp_tick) begin
        cur_duty_d[i] = DW'(nxt_x[i]);
        cmp_d[i]      = CW'(prod[i] >> DW);
      end
      if (accept && (int'(cmd_ch) == i)) begin
        tgt_duty_d[i] = cmd_duty;
        tgt_dir_d[i]  = cmd_dir;
      end
      if (brake) begin
        tgt_duty_d[i] = '0;
        cur_duty_d[i] = '0;
        cmp_d[i]      = '0;
      end
      pwm_d[i] = en && !brake && (cnt_q < cmp_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= '0;
      ready_q   <= 1'b0;
      pwm_q     <= '0;
      tgt_dir_q <= '0;
      cur_dir_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        tgt_duty_q[i] <= '0;
        cur_duty_q[i] <= '0;
        cmp_q[i]      <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      ready_q   <= ready_d;
      pwm_q     <= pwm_d;
      tgt_dir_q <= tgt_dir_d;
      cur_dir_q <= cur_dir_d;
      for (int i = 0; i < NCH; i++) begin
        tgt_duty_q[i] <= tgt_duty_d[i];
        cur_duty_q[i] <= cur_duty_d[i];
        cmp_q[i]      <= cmp_d[i];
      end
    end
  end

  always_comb begin
    at_target = '0;
    for (int i = 0; i < NCH; i++)
      at_target[i] = (cur_duty_q[i] == tgt_duty_q[i]) && (cur_dir_q[i] == tgt_dir_q[i]);
  end

  assign cmd_ready   = ready_q && !brake;
  assign pwm         = pwm_q;
  assign dir         = cur_dir_q;
  assign period_tick = boundary;

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// tb_motor_pwm_ramp: directed checks of the motor PWM ramp driver with a shortened PWM period (128 clocks).
// A second instance with RAMP_DIV=3 and NCH=1 covers the tick divider and out-of-range channel commands.
module tb_motor_pwm_ramp;
  localparam int P = 128;

  logic       clk = 1'b0;
  logic       rst_n, en, brake;
  logic       cmd_valid, cmd_ready, cmd_dir;
  logic [0:0] cmd_ch;
  logic [9:0] cmd_duty;
  logic [1:0] pwm, dir, at_target;
  logic       period_tick;

  logic       cmd_valid3, cmd_ready3, cmd_dir3;
  logic [0:0] cmd_ch3;
  logic [9:0] cmd_duty3;
  logic [0:0] pwm3, dir3, at_target3;
  logic       period_tick3;

  int n_run = 0, n_fail = 0;
  int hi1 = 0;
  bit hi1_en = 0;

  motor_pwm_ramp #(.NCH(2), .DW(10), .CLK_HZ(3_200_000), .PWM_HZ(25_000), .STEP(8), .RAMP_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .brake(brake),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_duty(cmd_duty), .cmd_dir(cmd_dir),
    .pwm(pwm), .dir(dir), .at_target(at_target), .period_tick(period_tick));

  motor_pwm_ramp #(.NCH(1), .DW(10), .CLK_HZ(3_200_000), .PWM_HZ(25_000), .STEP(8), .RAMP_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .brake(brake),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_ch(cmd_ch3), .cmd_duty(cmd_duty3), .cmd_dir(cmd_dir3),
    .pwm(pwm3), .dir(dir3), .at_target(at_target3), .period_tick(period_tick3));

  always #5 clk = ~clk;

  always @(negedge clk) if (hi1_en && pwm[1]) hi1++;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_run++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bnd(input bit use3);
    bit seen = 0;
    for (int i = 0; i < P + 4 && !seen; i++) begin
      if ((use3 ? period_tick3 : period_tick) === 1'b1) seen = 1;
      else step();
    end
    if (!seen) check("bnd_timeout", 0, 1);
  endtask

  task automatic next_tick(input bit use3);
    wait_bnd(use3);
    step();
  endtask

  task automatic send(input int ch, input int duty, input bit d);
    cmd_valid = 1'b1; cmd_ch = 1'(ch); cmd_duty = 10'(duty); cmd_dir = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic send3(input int ch, input int duty, input bit d);
    cmd_valid3 = 1'b1; cmd_ch3 = 1'(ch); cmd_duty3 = 10'(duty); cmd_dir3 = d;
    step();
    cmd_valid3 = 1'b0;
  endtask

  task automatic meas(output int h0, output int h1);
    h0 = 0; h1 = 0;
    for (int i = 0; i < P; i++) begin
      step();
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, h1, k, nt, prev, nchg;
    int chg_idx [3];
    int chg_val [3];
    int exp_cur [7] = '{24, 16, 8, 0, 0, 8, 16};
    int exp_dir [7] = '{0, 0, 0, 0, 1, 1, 1};

    rst_n = 1'b0; en = 1'b0; brake = 1'b0;
    cmd_valid = 1'b0; cmd_ch = '0; cmd_duty = '0; cmd_dir = 1'b0;
    cmd_valid3 = 1'b0; cmd_ch3 = '0; cmd_duty3 = '0; cmd_dir3 = 1'b0;
    #23;
    check("rst_pwm", pwm, 0);
    check("rst_dir", dir, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_ptick", period_tick, 0);
    check("rst_at_target", at_target, 3);
    step();
    rst_n = 1'b1; en = 1'b1;
    step();
    check("ready_after_rst", cmd_ready, 1);
    check("ready3_after_rst", cmd_ready3, 1);

    // ramp ch0 to 64
    step();
    wait_bnd(0);
    step();
    send(0, 64, 1'b0);
    for (int t = 1; t <= 8; t++) begin
      next_tick(0);
      check("t2_cur0", dut.cur_duty_q[0], 8 * t);
      check("t2_at_target0", at_target[0], (t == 8) ? 1 : 0);
    end
    meas(h0, h1);
    check("t2_high0", h0, 8);
    check("t2_high1", h1, 0);

    // reset mid-period with pwm high
    step(); step();
    check("t1_pwm_pre", pwm[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_pwm_rst", pwm, 0);
    check("t1_ready_rst", cmd_ready, 0);
    check("t1_at_target_rst", at_target, 3);
    check("t1_cur0_rst", dut.cur_duty_q[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t1_cnt_release", dut.cnt_q, 0);
    k = 0;
    while (period_tick !== 1'b1 && k < P + 4) begin step(); k++; end
    check("t1_first_period", k, P - 1);
    step();

    // ch1 up to 32 fwd, then reverse to 16
    send(1, 32, 1'b0);
    for (int t = 0; t < 4; t++) next_tick(0);
    check("t3_cur1_setup", dut.cur_duty_q[1], 32);
    send(1, 16, 1'b1);
    for (int t = 0; t < 7; t++) begin
      next_tick(0);
      check("t3_cur1", dut.cur_duty_q[1], exp_cur[t]);
      check("t3_dir1", dir[1], exp_dir[t]);
      if (t == 4) check("t3_pwm1_at_flip", pwm[1], 0);
    end
    check("t3_at_target1", at_target[1], 1);

    // brake mid-ramp at 40
    send(0, 64, 1'b0);
    for (int t = 0; t < 5; t++) next_tick(0);
    check("t4_cur0_pre", dut.cur_duty_q[0], 40);
    step(); step();
    check("t4_pwm0_pre", pwm[0], 1);
    brake = 1'b1;
    #1;
    check("t4_ready_brake", cmd_ready, 0);
    step();
    check("t4_pwm_brake", pwm, 0);
    check("t4_cur0_brake", dut.cur_duty_q[0], 0);
    check("t4_cur1_brake", dut.cur_duty_q[1], 0);
    check("t4_dir_brake", dir, 2);
    next_tick(0);
    brake = 1'b0;
    #1;
    check("t4_ready_release", cmd_ready, 1);
    next_tick(0);
    next_tick(0);
    check("t4_cur0_after", dut.cur_duty_q[0], 0);
    check("t4_cur1_after", dut.cur_duty_q[1], 0);
    check("t4_at_target_after", at_target, 3);
    check("t4_dir_after", dir, 2);

    // command landing exactly on the boundary cycle
    wait_bnd(0);
    check("t5_on_tick", period_tick, 1);
    cmd_valid = 1'b1; cmd_ch = 1'b0; cmd_duty = 10'd16; cmd_dir = 1'b0;
    check("t5_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    check("t5_no_step", dut.cur_duty_q[0], 0);
    check("t5_at_target0", at_target[0], 0);
    next_tick(0);
    check("t5_first_step", dut.cur_duty_q[0], 8);
    next_tick(0);
    check("t5_second_step", dut.cur_duty_q[0], 16);

    // full-scale duty on ch0, zero duty on ch1
    send(0, 1023, 1'b0);
    send(1, 0, 1'b0);
    hi1 = 0; hi1_en = 1;
    nt = 0;
    while (at_target[0] !== 1'b1 && nt < 140) begin next_tick(0); nt++; end
    check("t6_ticks_to_full", nt, 126);
    check("t6_cur0_full", dut.cur_duty_q[0], 1023);
    meas(h0, h1);
    hi1_en = 0;
    check("t6_high0_full", h0, 127);
    check("t6_high1_zero", h1, 0);
    check("t6_hi1_total", hi1, 0);
    check("t6_dir1", dir[1], 0);

    // RAMP_DIV=3 instance; channel 1 does not exist there
    send3(1, 100, 1'b0);
    check("t6_oob_at_target", at_target3, 1);
    check("t6_oob_tgt", dut3.tgt_duty_q[0], 0);
    send3(0, 24, 1'b0);
    nchg = 0;
    for (int b = 0; b < 10; b++) begin
      prev = int'(dut3.cur_duty_q[0]);
      next_tick(1);
      if (int'(dut3.cur_duty_q[0]) != prev) begin
        if (nchg < 3) begin chg_idx[nchg] = b; chg_val[nchg] = int'(dut3.cur_duty_q[0]); end
        nchg++;
      end
    end
    check("t6_div_nchg", nchg, 3);
    if (nchg == 3) begin
      check("t6_div_gap1", chg_idx[1] - chg_idx[0], 3);
      check("t6_div_gap2", chg_idx[2] - chg_idx[1], 3);
      check("t6_div_val0", chg_val[0], 8);
      check("t6_div_val2", chg_val[2], 24);
    end
    check("t6_div_final", dut3.cur_duty_q[0], 24);

    // en=0 holds the counter and freezes the ramp
    en = 1'b0;
    step();
    check("en0_cnt", dut.cnt_q, 0);
    check("en0_pwm", pwm, 0);
    k = 0;
    for (int i = 0; i < P + 8; i++) begin
      step();
      if (period_tick === 1'b1 || pwm != 2'b00) k++;
    end
    check("en0_quiet", k, 0);
    check("en0_cur0_frozen", dut.cur_duty_q[0], 1023);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
